// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: checker FSM state constants and a width-agnostic
// Gray-to-binary helper used by both ends of the count link.
package gray_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_TRACK = 2'd1;
  localparam state_t ST_ERROR = 2'd2;

  localparam int GRAY_MAX_W = 32;

  // Callers zero-extend narrower words; zeros above the MSB leave the
  // prefix-XOR of the low bits unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at or above it.
module gray2bin_comb #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin[WIDTH-1] = gray[WIDTH-1];

  for (genvar i = WIDTH-2; i >= 0; i--) begin : g_bit
    assign bin[i] = bin[i+1] ^ gray[i];
  end

endmodule

// File: rtl/gray_seq_checker.sv
// Consumer end of a Gray-coded count link: registers the binary value of each
// sample and checks that the stream only holds or advances by one step.
module gray_seq_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  input  logic [WIDTH-1:0] Gray_In,
  output logic [WIDTH-1:0] Bin_Out,
  output logic             Out_Valid,
  output logic             Wrap,
  output logic             Step_Err,
  output logic [WIDTH-1:0] Err_Gray,
  output logic [CNT_W-1:0] Step_Cnt
);

  localparam logic [WIDTH-1:0] BIN_MAX = '1;
  localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] bin_now;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] prev_inc;
  logic             is_hold;
  logic             is_step;
  state_t           state, state_nxt;
  logic             do_step, do_wrap, do_err;

  gray2bin_comb #(.WIDTH(WIDTH)) u_g2b (
    .gray (Gray_In),
    .bin  (bin_now)
  );

  assign prev_inc = prev_bin + BIN_ONE;
  assign is_hold  = (bin_now == prev_bin);
  assign is_step  = (bin_now == prev_inc);

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (In_Valid) state_nxt = ST_TRACK;
      ST_TRACK: if (In_Valid && !is_hold && !is_step) state_nxt = ST_ERROR;
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The first sample after IDLE is only a reference; ERROR freezes all checks.
  always_comb begin
    do_step = 1'b0;
    do_wrap = 1'b0;
    do_err  = 1'b0;
    if (state == ST_TRACK && In_Valid) begin
      do_step = is_step;
      do_wrap = is_step && (prev_bin == BIN_MAX);
      do_err  = !is_hold && !is_step;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Bin_Out   <= '0;
      prev_bin  <= '0;
      Out_Valid <= 1'b0;
      Wrap      <= 1'b0;
      Step_Err  <= 1'b0;
      Err_Gray  <= '0;
      Step_Cnt  <= '0;
    end else begin
      Out_Valid <= In_Valid;
      if (In_Valid) begin
        Bin_Out  <= bin_now;
        prev_bin <= bin_now;
      end
      if (do_step && Step_Cnt != CNT_MAX) Step_Cnt <= Step_Cnt + CNT_ONE;
      if (do_wrap) Wrap <= 1'b1;
      if (do_err) begin
        Step_Err <= 1'b1;
        Err_Gray <= Gray_In;
      end
    end
  end

endmodule

// File: tb/tb_gray_seq_checker.sv
// Bench for gray_seq_checker: vector table, hand-written corner sequences and a
// randomized run against a behavioural model of the stepping rules.
module tb_gray_seq_checker;

  logic       Clk;
  logic       Reset, In_Valid;
  logic [2:0] Gray_In;
  logic [2:0] Bin_Out, Err_Gray;
  logic       Out_Valid, Wrap, Step_Err;
  logic [7:0] Step_Cnt;

  logic       s_rst, s_vld;
  logic [2:0] s_gray;
  logic [2:0] s_bin, s_errg;
  logic       s_ov, s_wrap, s_err;
  logic [3:0] s_cnt;

  int total = 0;
  int bad   = 0;

  gray_seq_checker #(.WIDTH(3), .CNT_W(8)) u_dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .Gray_In(Gray_In),
    .Bin_Out(Bin_Out), .Out_Valid(Out_Valid), .Wrap(Wrap), .Step_Err(Step_Err),
    .Err_Gray(Err_Gray), .Step_Cnt(Step_Cnt)
  );

  gray_seq_checker #(.WIDTH(3), .CNT_W(4)) u_sat (
    .Clk(Clk), .Reset(s_rst), .In_Valid(s_vld), .Gray_In(s_gray),
    .Bin_Out(s_bin), .Out_Valid(s_ov), .Wrap(s_wrap), .Step_Err(s_err),
    .Err_Gray(s_errg), .Step_Cnt(s_cnt)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic       rst, vld;
    logic [2:0] gray;
    logic [2:0] bin;
    logic       ov, wrap, err;
    logic [2:0] errg;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic [2:0] g, logic [2:0] b,
                              logic o, logic w, logic e, logic [2:0] eg, int c);
    vec_t x;
    x.rst = r; x.vld = v; x.gray = g; x.bin = b; x.ov = o;
    x.wrap = w; x.err = e; x.errg = eg; x.cnt = c;
    return x;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic v, logic [2:0] g);
    Reset = r; In_Valid = v; Gray_In = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(string tag, logic [2:0] b, logic o, logic w, logic e,
                         logic [2:0] eg, int c);
    chk({tag, ".bin"},  int'(Bin_Out),  int'(b));
    chk({tag, ".ov"},   int'(Out_Valid), int'(o));
    chk({tag, ".wrap"}, int'(Wrap),     int'(w));
    chk({tag, ".err"},  int'(Step_Err), int'(e));
    chk({tag, ".errg"}, int'(Err_Gray), int'(eg));
    chk({tag, ".cnt"},  int'(Step_Cnt), c);
  endtask

  // Reference helpers written as plain arithmetic on integers.
  function automatic int g2b(int g);
    int b = 0;
    for (int s = 0; s < 3; s++) b ^= (g >> s);
    return b & 7;
  endfunction

  function automatic int b2g(int b);
    return (b ^ (b >> 1)) & 7;
  endfunction

  // Behavioural model state
  bit m_have, m_err, m_wrap, m_ov;
  int m_prev, m_cnt, m_errg, m_bin;

  task automatic model_step(bit r, bit v, int g);
    int b;
    if (r) begin
      m_have = 0; m_err = 0; m_wrap = 0; m_ov = 0;
      m_prev = 0; m_cnt = 0; m_errg = 0; m_bin = 0;
      return;
    end
    m_ov = v;
    if (!v) return;
    b = g2b(g);
    m_bin = b;
    if (!m_have) m_have = 1;
    else if (!m_err) begin
      if (b == m_prev) ;
      else if (b == (m_prev + 1) % 8) begin
        if (m_cnt < 255) m_cnt++;
        if (m_prev == 7) m_wrap = 1;
      end else begin
        m_err = 1;
        m_errg = g;
      end
    end
    m_prev = b;
  endtask

  initial begin
    int pulses;
    Reset = 1; In_Valid = 0; Gray_In = 0;
    s_rst = 1; s_vld = 0; s_gray = 0;

    // full cycle, illegal step, non-zero start
    tbl.push_back(mk(1,1,3'b000, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,3'b000, 0,1,0,0,0,0));
    tbl.push_back(mk(0,1,3'b001, 1,1,0,0,0,1));
    tbl.push_back(mk(0,1,3'b011, 2,1,0,0,0,2));
    tbl.push_back(mk(0,1,3'b010, 3,1,0,0,0,3));
    tbl.push_back(mk(0,1,3'b110, 4,1,0,0,0,4));
    tbl.push_back(mk(0,1,3'b111, 5,1,0,0,0,5));
    tbl.push_back(mk(0,1,3'b101, 6,1,0,0,0,6));
    tbl.push_back(mk(0,1,3'b100, 7,1,0,0,0,7));
    tbl.push_back(mk(0,1,3'b000, 0,1,1,0,0,8));
    tbl.push_back(mk(0,0,3'b101, 0,0,1,0,0,8));
    tbl.push_back(mk(1,0,3'b000, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,3'b001, 1,1,0,0,0,0));
    tbl.push_back(mk(0,1,3'b010, 3,1,0,1,3'b010,0));
    tbl.push_back(mk(0,1,3'b110, 4,1,0,1,3'b010,0));
    tbl.push_back(mk(0,1,3'b111, 5,1,0,1,3'b010,0));
    tbl.push_back(mk(0,0,3'b011, 5,0,0,1,3'b010,0));
    tbl.push_back(mk(1,0,3'b000, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,3'b110, 4,1,0,0,0,0));
    tbl.push_back(mk(0,1,3'b111, 5,1,0,0,0,1));
    tbl.push_back(mk(0,1,3'b000, 0,1,0,1,3'b000,1));
    tbl.push_back(mk(0,1,3'b001, 1,1,0,1,3'b000,1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].gray);
      chk_all($sformatf("vec%0d", i), tbl[i].bin, tbl[i].ov, tbl[i].wrap,
              tbl[i].err, tbl[i].errg, tbl[i].cnt);
    end

    // hold and gaps: only valid cycles pulse Out_Valid
    drive(1, 0, 0);
    pulses = 0;
    drive(0, 1, 3'b011); pulses += int'(Out_Valid);
    drive(0, 1, 3'b011); pulses += int'(Out_Valid);
    drive(0, 0, 3'b101); pulses += int'(Out_Valid);
    drive(0, 0, 3'b110); pulses += int'(Out_Valid);
    chk("gap.bin_hold", int'(Bin_Out), 2);
    drive(0, 1, 3'b010); pulses += int'(Out_Valid);
    drive(0, 0, 3'b000); pulses += int'(Out_Valid);
    chk("gap.pulses", pulses, 3);
    chk("gap.cnt", int'(Step_Cnt), 1);
    chk("gap.err", int'(Step_Err), 0);
    chk("gap.bin", int'(Bin_Out), 3);

    // reset mid-stream, reset dominates In_Valid
    drive(1, 0, 0);
    drive(0, 1, 3'b000);
    drive(0, 1, 3'b001);
    drive(0, 1, 3'b011);
    drive(0, 1, 3'b010);
    chk("mid.cnt_pre", int'(Step_Cnt), 3);
    drive(1, 1, 3'b110);
    chk_all("mid.rst", 0, 0, 0, 0, 0, 0);
    drive(0, 1, 3'b101);
    chk_all("mid.ref", 6, 1, 0, 0, 0, 0);

    // saturation on the 4-bit counter instance
    Reset = 0; In_Valid = 0;
    s_rst = 1; s_vld = 0; s_gray = 0;
    @(posedge Clk); #1;
    s_rst = 0; s_vld = 1; s_gray = 3'(b2g(0));
    @(posedge Clk); #1;
    for (int i = 1; i <= 20; i++) begin
      s_gray = 3'(b2g(i % 8));
      @(posedge Clk); #1;
      if (i == 7) chk("sat.wrap_before", int'(s_wrap), 0);
      if (i == 8) chk("sat.wrap_after", int'(s_wrap), 1);
    end
    chk("sat.cnt", int'(s_cnt), 15);
    chk("sat.err", int'(s_err), 0);
    chk("sat.wrap", int'(s_wrap), 1);
    s_vld = 0;

    // randomized run against the model
    drive(1, 0, 0);
    model_step(1, 0, 0);
    for (int n = 0; n < 400; n++) begin
      bit r, v;
      int g, sel;
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 19);
      if (sel < 14)      g = b2g((m_prev + 1) % 8);
      else if (sel < 18) g = b2g(m_prev);
      else               g = $urandom_range(0, 7);
      drive(r, v, 3'(g));
      model_step(r, v, g);
      chk_all($sformatf("rnd%0d", n), 3'(m_bin), m_ov, m_wrap, m_err,
              3'(m_errg), m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
